// File: rtl/digpot_step_ctrl_pkg.sv
// Shared state encoding and default sizing for the X9C-style digital pot stepper
// (also consumed by the Wishbone register block).
package digpot_step_ctrl_pkg;

  localparam int unsigned TAPS_DEF        = 100;
  localparam int unsigned POS_W_DEF       = 7;
  localparam int unsigned STORE_TICKS_DEF = 2000;

  typedef enum logic [3:0] {
    HOME_SETUP = 4'd0,
    HOME_LO    = 4'd1,
    HOME_HI    = 4'd2,
    IDLE       = 4'd3,
    SETUP      = 4'd4,
    STEP_LO    = 4'd5,
    STEP_HI    = 4'd6,
    END_CS     = 4'd7,
    END_INC    = 4'd8,
    STORE_WAIT = 4'd9
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digpot_tick_det.sv
// Rising-edge detector on the divider square wave; emits a one-clk pacing tick.
module digpot_tick_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_clk_i,
  output logic tick_o
);

  logic div_clk_q;

  // Previous divider level, cleared so a high level right after reset counts as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= div_clk_i;
    end
  end

  assign tick_o = div_clk_i & ~div_clk_q;

endmodule

// File: rtl/digpot_step_ctrl.sv
// Up/down digital pot stepper: homes to tap 0 after reset, then walks the wiper to requested taps.
// Build option DIGPOT_STORE_EN: deselect with INC high (nonvolatile store) and wait STORE_TICKS ticks.
module digpot_step_ctrl
  import digpot_step_ctrl_pkg::*;
#(
  parameter int unsigned TAPS        = TAPS_DEF,
  parameter int unsigned POS_W       = POS_W_DEF,
  parameter int unsigned STORE_TICKS = STORE_TICKS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             div_clk_i,
  input  logic             req_valid_i,
  input  logic [POS_W-1:0] req_pos_i,
  output logic             req_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [POS_W-1:0] wiper_pos_o,
  output logic             pot_cs_n_o,
  output logic             pot_inc_n_o,
  output logic             pot_ud_o
);

  localparam int unsigned      CNT_W   = $clog2(max_u(TAPS, STORE_TICKS) + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(TAPS - 1);

  logic             tick_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [POS_W-1:0] wiper_q, target_q, req_tgt_d, step_pos_d;
  logic             cs_n_q, inc_n_q, ud_q, done_q, ready_q, busy_q;

  digpot_tick_det u_tick_det (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .div_clk_i (div_clk_i),
    .tick_o    (tick_s)
  );

  assign req_tgt_d = (req_pos_i > POS_MAX) ? POS_MAX : req_pos_i;

  // Next wiper position for the current direction, pinned at both ends of the track.
  always_comb begin
    step_pos_d = wiper_q;
    if (ud_q) begin
      if (wiper_q != POS_MAX) step_pos_d = wiper_q + POS_W'(1);
      else                    step_pos_d = wiper_q;
    end else begin
      if (wiper_q != {POS_W{1'b0}}) step_pos_d = wiper_q - POS_W'(1);
      else                          step_pos_d = wiper_q;
    end
  end

  // Sequencer: pins only move on ticks; the IDLE handshake is evaluated every clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HOME_SETUP;
      cnt_q    <= {CNT_W{1'b0}};
      wiper_q  <= {POS_W{1'b0}};
      target_q <= {POS_W{1'b0}};
      cs_n_q   <= 1'b1;
      inc_n_q  <= 1'b1;
      ud_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        HOME_SETUP: if (tick_s) begin
          cs_n_q  <= 1'b0;
          ud_q    <= 1'b0;
          cnt_q   <= CNT_W'(TAPS);
          state_q <= HOME_LO;
        end
        HOME_LO: if (tick_s) begin
          inc_n_q <= 1'b0;
          cnt_q   <= cnt_q - CNT_W'(1);
`ifdef DIGPOT_STORE_EN
          state_q <= HOME_HI;
`else
          state_q <= (cnt_q == CNT_W'(1)) ? END_CS : HOME_HI;
`endif
        end
        HOME_HI: if (tick_s) begin
          inc_n_q <= 1'b1;
          state_q <= (cnt_q == {CNT_W{1'b0}}) ? END_CS : HOME_LO;
        end
        IDLE: if (req_valid_i && ready_q) begin
          // A request for the current tap completes without touching the pins.
          if (req_tgt_d == wiper_q) begin
            done_q <= 1'b1;
          end else begin
            target_q <= req_tgt_d;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: if (tick_s) begin
          cs_n_q  <= 1'b0;
          ud_q    <= (target_q > wiper_q);
          state_q <= STEP_LO;
        end
        STEP_LO: if (tick_s) begin
          inc_n_q <= 1'b0;
          wiper_q <= step_pos_d;
`ifdef DIGPOT_STORE_EN
          state_q <= STEP_HI;
`else
          state_q <= (step_pos_d == target_q) ? END_CS : STEP_HI;
`endif
        end
        STEP_HI: if (tick_s) begin
          inc_n_q <= 1'b1;
          state_q <= (wiper_q == target_q) ? END_CS : STEP_LO;
        end
        END_CS: if (tick_s) begin
          cs_n_q <= 1'b1;
`ifdef DIGPOT_STORE_EN
          cnt_q   <= CNT_W'(STORE_TICKS);
          state_q <= STORE_WAIT;
`else
          state_q <= END_INC;
`endif
        end
        END_INC: if (tick_s) begin
          inc_n_q <= 1'b1;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef DIGPOT_STORE_EN
        STORE_WAIT: if (tick_s) begin
          if (cnt_q <= CNT_W'(1)) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        default: begin
          cs_n_q  <= 1'b1;
          inc_n_q <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= HOME_SETUP;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wiper_pos_o = wiper_q;
  assign pot_cs_n_o  = cs_n_q;
  assign pot_inc_n_o = inc_n_q;
  assign pot_ud_o    = ud_q;

endmodule
